// File: rtl/fm_sched_pkg.sv
// Shared types and constants for the FM transmit scheduler.
// Holds the state codes, the requester id type and the counter sizing helper.
package fm_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_GUARD  = 2'd1;
  localparam state_t S_ACTIVE = 2'd2;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam logic [11:0] MID_CODE_DEF = 12'h800;

  // Width that holds max(a,b)-1; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic req_id_t other_req(req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
// Shared by the guard and active phases of the scheduler.
module sched_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/fm_tx_scheduler.sv
// Round-robin time-division sharing of one FM modulator between requesters A and B,
// with a muted guard interval after every grant change.
module fm_tx_scheduler
  import fm_sched_pkg::*;
#(
  parameter int unsigned       DATA_W    = 12,
  parameter int unsigned       FW_W      = 32,
  parameter int unsigned       SLOT_CYC  = 50000,
  parameter int unsigned       GUARD_CYC = 500,
  parameter logic [DATA_W-1:0] MID_CODE  = DATA_W'(MID_CODE_DEF)
) (
  input  logic              clk_in,
  input  logic              RST,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] audio_a,
  input  logic [DATA_W-1:0] audio_b,
  input  logic [FW_W-1:0]   fre_word_a,
  input  logic [FW_W-1:0]   fre_word_b,
  output logic              grant_a,
  output logic              grant_b,
  output logic              tx_en,
  output logic [DATA_W-1:0] module_sig,
  output logic [FW_W-1:0]   fre_word,
  output logic              fre_load
);

  localparam int unsigned      CNT_W    = cnt_width(SLOT_CYC, GUARD_CYC);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LD  = CNT_W'(SLOT_CYC - 1);

  state_t            state_q, state_d;
  req_id_t           sel_q, sel_d;
  req_id_t           last_q, last_d;
  req_id_t           new_sel;
  logic              start_guard;
  logic              req_sel, req_oth;
  logic              cnt_load, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              grant_a_d, grant_b_d, tx_en_d, fre_load_d;
  logic [DATA_W-1:0] module_sig_d;
  logic [FW_W-1:0]   fre_word_d;

  sched_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_in   (clk_in),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign req_sel = (sel_q == REQ_A) ? req_a : req_b;
  assign req_oth = (sel_q == REQ_A) ? req_b : req_a;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    new_sel      = sel_q;
    start_guard  = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = GUARD_LD;
    fre_word_d   = fre_word;
    fre_load_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          new_sel     = (req_a && req_b) ? other_req(last_q) : (req_a ? REQ_A : REQ_B);
          start_guard = 1'b1;
        end
      end
      S_GUARD: begin
        if (!req_sel) begin
          state_d = S_IDLE;
          last_d  = sel_q;
        end else if (cnt_zero) begin
          state_d      = S_ACTIVE;
          cnt_load     = 1'b1;
          cnt_load_val = SLOT_LD;
        end
      end
      S_ACTIVE: begin
        // A drop wins over a coincident expiry: the own-request reload needs req_sel high.
        if (!req_sel || cnt_zero) begin
          last_d = sel_q;
          if (req_oth) begin
            new_sel     = other_req(sel_q);
            start_guard = 1'b1;
          end else if (req_sel) begin
            cnt_load     = 1'b1;
            cnt_load_val = SLOT_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_guard) begin
      state_d      = S_GUARD;
      sel_d        = new_sel;
      fre_word_d   = (new_sel == REQ_A) ? fre_word_a : fre_word_b;
      fre_load_d   = 1'b1;
      cnt_load     = 1'b1;
      cnt_load_val = GUARD_LD;
    end

    grant_a_d    = (state_d != S_IDLE) && (sel_d == REQ_A);
    grant_b_d    = (state_d != S_IDLE) && (sel_d == REQ_B);
    tx_en_d      = (state_d == S_ACTIVE);
    module_sig_d = MID_CODE;
    if (state_d == S_ACTIVE) begin
      module_sig_d = (sel_d == REQ_A) ? audio_a : audio_b;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sel_q      <= REQ_A;
      last_q     <= REQ_B;
      grant_a    <= 1'b0;
      grant_b    <= 1'b0;
      tx_en      <= 1'b0;
      module_sig <= MID_CODE;
      fre_word   <= '0;
      fre_load   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      grant_a    <= grant_a_d;
      grant_b    <= grant_b_d;
      tx_en      <= tx_en_d;
      module_sig <= module_sig_d;
      fre_word   <= fre_word_d;
      fre_load   <= fre_load_d;
    end
  end

endmodule

// File: tb/tb_fm_tx_scheduler.sv
// Bench for fm_tx_scheduler: a slot-level model checked every cycle, plus directed
// literal expectations at the interesting edges.
module tb_fm_tx_scheduler;

  localparam int unsigned SLOT  = 8;
  localparam int unsigned GUARD = 3;
  localparam logic [11:0] MID   = 12'h800;
  localparam logic [31:0] FWA   = 32'h0000_1000;
  localparam logic [31:0] FWB   = 32'h0000_2000;

  logic        clk;
  logic        rst;
  logic        req_a, req_b;
  logic [11:0] audio_a, audio_b;
  logic [31:0] fre_word_a, fre_word_b;
  logic        grant_a, grant_b, tx_en, fre_load;
  logic [11:0] module_sig;
  logic [31:0] fre_word;

  int checks = 0;
  int errors = 0;

  fm_tx_scheduler #(
    .DATA_W    (12),
    .FW_W      (32),
    .SLOT_CYC  (SLOT),
    .GUARD_CYC (GUARD),
    .MID_CODE  (MID)
  ) dut (
    .clk_in     (clk),
    .RST        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .audio_a    (audio_a),
    .audio_b    (audio_b),
    .fre_word_a (fre_word_a),
    .fre_word_b (fre_word_b),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .tx_en      (tx_en),
    .module_sig (module_sig),
    .fre_word   (fre_word),
    .fre_load   (fre_load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0 = none, 1 = A, 2 = B; left = cycles remaining in the current phase.
  int          m_own, m_last, m_left;
  bit          m_live;
  bit          m_valid = 1'b0;
  logic        e_ga, e_gb, e_tx, e_fl;
  logic [11:0] e_ms;
  logic [31:0] e_fw;

  function automatic bit req_of(int p);
    return (p == 1) ? req_a : req_b;
  endfunction

  function automatic int other_of(int p);
    return (p == 1) ? 2 : 1;
  endfunction

  task automatic grant_to(input int p);
    m_own  = p;
    m_live = 1'b0;
    m_left = GUARD;
    e_fw   = (p == 1) ? fre_word_a : fre_word_b;
    e_fl   = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_own   = 0;
      m_last  = 2;
      m_live  = 1'b0;
      m_left  = 0;
      e_fw    = '0;
      e_fl    = 1'b0;
      e_ms    = MID;
    end else begin
      e_fl = 1'b0;
      if (m_own == 0) begin
        if (req_a && req_b) grant_to(other_of(m_last));
        else if (req_a) grant_to(1);
        else if (req_b) grant_to(2);
      end else if (!m_live) begin
        if (!req_of(m_own)) begin
          m_last = m_own;
          m_own  = 0;
        end else if (m_left == 1) begin
          m_live = 1'b1;
          m_left = SLOT;
        end else begin
          m_left--;
        end
      end else begin
        if (!req_of(m_own) || m_left == 1) begin
          m_last = m_own;
          if (req_of(other_of(m_own))) grant_to(other_of(m_own));
          else if (req_of(m_own)) m_left = SLOT;
          else begin
            m_own  = 0;
            m_live = 1'b0;
          end
        end else begin
          m_left--;
        end
      end
      if (m_live && m_own != 0) e_ms = (m_own == 1) ? audio_a : audio_b;
      else e_ms = MID;
    end
    e_ga = (m_own == 1);
    e_gb = (m_own == 2);
    e_tx = m_live && (m_own != 0);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("grant_a", 32'(grant_a), 32'(e_ga));
      check("grant_b", 32'(grant_b), 32'(e_gb));
      check("tx_en", 32'(tx_en), 32'(e_tx));
      check("module_sig", 32'(module_sig), 32'(e_ms));
      check("fre_word", fre_word, e_fw);
      check("fre_load", 32'(fre_load), 32'(e_fl));
      check("grant_exclusive", 32'(grant_a & grant_b), 32'd0);
    end
  end

  logic [11:0] prev_a, prev_b;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      prev_a  = audio_a;
      prev_b  = audio_b;
      audio_a = 12'($urandom);
      audio_b = 12'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ga"}, 32'(grant_a), 32'd0);
    check({tag, "_gb"}, 32'(grant_b), 32'd0);
    check({tag, "_tx"}, 32'(tx_en), 32'd0);
    check({tag, "_ms"}, 32'(module_sig), 32'h800);
    check({tag, "_fw"}, fre_word, 32'd0);
    check({tag, "_fl"}, 32'(fre_load), 32'd0);
  endtask

  // Drive one requester-A grant from idle and pin the guard timing on literals.
  task automatic grant_a_from_idle(input string tag);
    step(1);
    check({tag, "_t1_ga"}, 32'(grant_a), 32'd1);
    check({tag, "_t1_fw"}, fre_word, 32'h1000);
    check({tag, "_t1_fl"}, 32'(fre_load), 32'd1);
    check({tag, "_t1_tx"}, 32'(tx_en), 32'd0);
    step(2);
    check({tag, "_t3_tx"}, 32'(tx_en), 32'd0);
    check({tag, "_t3_fl"}, 32'(fre_load), 32'd0);
    check({tag, "_t3_ms"}, 32'(module_sig), 32'h800);
    step(1);
    check({tag, "_t4_tx"}, 32'(tx_en), 32'd1);
    check({tag, "_t4_ms"}, 32'(module_sig), 32'(prev_a));
  endtask

  initial begin
    rst        = 1'b1;
    req_a      = 1'b1;
    req_b      = 1'b1;
    audio_a    = 12'h123;
    audio_b    = 12'h456;
    fre_word_a = FWA;
    fre_word_b = FWB;

    // Reset held with both requests high.
    step(1);
    check_reset_outputs("rst1");
    step(1);
    check_reset_outputs("rst2");

    // Both request from release: A first, then swap to B, then back to A.
    rst = 1'b0;
    grant_a_from_idle("rr");
    step(7);
    check("rr_t11_ga", 32'(grant_a), 32'd1);
    check("rr_t11_tx", 32'(tx_en), 32'd1);
    step(1);
    check("rr_t12_ga", 32'(grant_a), 32'd0);
    check("rr_t12_gb", 32'(grant_b), 32'd1);
    check("rr_t12_fw", fre_word, 32'h2000);
    check("rr_t12_fl", 32'(fre_load), 32'd1);
    check("rr_t12_ms", 32'(module_sig), 32'h800);
    step(2);
    check("rr_t14_ms", 32'(module_sig), 32'h800);
    check("rr_t14_tx", 32'(tx_en), 32'd0);
    step(1);
    check("rr_t15_tx", 32'(tx_en), 32'd1);
    check("rr_t15_ms", 32'(module_sig), 32'(prev_b));
    step(7);
    check("rr_t22_gb", 32'(grant_b), 32'd1);
    step(1);
    check("rr_t23_ga", 32'(grant_a), 32'd1);
    check("rr_t23_gb", 32'(grant_b), 32'd0);
    check("rr_t23_fw", fre_word, 32'h1000);
    check("rr_t23_fl", 32'(fre_load), 32'd1);

    // Single requester A held: one guard, then seamless active across slot reloads.
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    req_a = 1'b1;
    grant_a_from_idle("solo");
    for (int i = 0; i < 30; i++) begin
      step(1);
      check("solo_tx", 32'(tx_en), 32'd1);
      check("solo_ga", 32'(grant_a), 32'd1);
      check("solo_fl", 32'(fre_load), 32'd0);
      check("solo_ms", 32'(module_sig), 32'(prev_a));
    end

    // A drops in its 4th active cycle; the next tie then goes to B.
    rst   = 1'b1;
    req_a = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    req_a = 1'b1;
    grant_a_from_idle("drop");
    step(3);
    req_a = 1'b0;
    step(1);
    check("drop_tx", 32'(tx_en), 32'd0);
    check("drop_ga", 32'(grant_a), 32'd0);
    check("drop_ms", 32'(module_sig), 32'h800);
    req_a = 1'b1;
    req_b = 1'b1;
    step(1);
    check("drop_next_gb", 32'(grant_b), 32'd1);
    check("drop_next_ga", 32'(grant_a), 32'd0);
    check("drop_next_fw", fre_word, 32'h2000);

    // Reset mid-guard, then mid-active; each new grant gets a full guard.
    rst = 1'b1;
    step(1);
    check_reset_outputs("rst_guard");
    rst = 1'b0;
    grant_a_from_idle("after_rg");
    step(2);
    rst = 1'b1;
    step(1);
    check_reset_outputs("rst_active");
    rst = 1'b0;
    grant_a_from_idle("after_ra");

    req_a = 1'b0;
    req_b = 1'b0;
    step(3);
    check("end_idle_ga", 32'(grant_a), 32'd0);
    check("end_idle_gb", 32'(grant_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
